// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - decode-side handshake and operand bundle for div_unit
//
// Signals:
//   div_inst   start request (decode has a divide/remainder)
//   divsel     3-bit op: 001 div, 010 divu, 011 rem, 100 remu
//   flush      pipeline flush, aborts the operation in flight
//   dividend   rs1 value
//   divisor    rs2 value
//   div_busy   operation in flight
//   div_ready  one-cycle result-valid pulse
//   div_result quotient or remainder
// Modports: master = decode/pipeline side, slave = divider side.

interface div_unit_if;
  logic        div_inst;
  logic [2:0]  divsel;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_busy;
  logic        div_ready;
  logic [31:0] div_result;

  modport master (
    output div_inst, divsel, flush, dividend, divisor,
    input  div_busy, div_ready, div_result
  );

  modport slave (
    input  div_inst, divsel, flush, dividend, divisor,
    output div_busy, div_ready, div_result
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M div/divu/rem/remu
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    div_unit_if.slave (div_inst, divsel, flush, dividend, divisor in;
//          div_busy, div_ready, div_result out)
// States IDLE -> CALC (32 cycles) -> FIX -> DONE; div_ready is high in DONE.
// Optional macro DIV_UNIT_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |dividend| < |divisor| skip CALC and go straight to FIX.

module div_unit (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_sel;
  logic [31:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] r_rem;      // partial remainder magnitude
  logic [31:0] r_dsr;      // divisor magnitude
  logic        r_qneg;
  logic        r_rneg;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_legal;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic        w_start;
  logic        w_early;
  logic [31:0] w_early_quo;
  logic [31:0] w_early_rem;
  logic [33:0] w_trial;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_fix_val;

  assign w_legal  = (bus.divsel == 3'b001) || (bus.divsel == 3'b010) ||
                    (bus.divsel == 3'b011) || (bus.divsel == 3'b100);
  assign w_signed = (bus.divsel == 3'b001) || (bus.divsel == 3'b011);
  assign w_a_neg  = w_signed & bus.dividend[31];
  assign w_b_neg  = w_signed & bus.divisor[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - bus.dividend) : bus.dividend;
  assign w_b_mag  = w_b_neg ? (32'd0 - bus.divisor) : bus.divisor;
  assign w_b_zero = (bus.divisor == 32'd0);

  assign w_start = bus.div_inst & ~bus.flush & w_legal &
                   ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef DIV_UNIT_EARLY_OUT_EN
  logic w_ovf;
  logic w_small;
  assign w_ovf   = w_signed && (bus.dividend == 32'h8000_0000) &&
                   (bus.divisor == 32'hFFFF_FFFF);
  assign w_small = (w_a_mag < w_b_mag);
  assign w_early = w_b_zero | w_ovf | w_small;
  // Preloaded magnitudes are exactly what 32 CALC iterations would leave behind.
  assign w_early_quo = w_b_zero ? 32'hFFFF_FFFF : (w_ovf ? 32'h8000_0000 : 32'd0);
  assign w_early_rem = w_ovf ? 32'd0 : w_a_mag;
`else
  assign w_early     = 1'b0;
  assign w_early_quo = 32'd0;
  assign w_early_rem = 32'd0;
`endif

  // Shift the next dividend bit into the remainder and try subtracting.
  assign w_trial = {1'b0, r_rem, r_quo[31]} - {2'b00, r_dsr};

  assign w_q_fix   = r_qneg ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix   = r_rneg ? (32'd0 - r_rem) : r_rem;
  assign w_fix_val = ((r_sel == 3'b001) || (r_sel == 3'b010)) ? w_q_fix : w_r_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_early ? S_FIX : S_CALC;
      S_CALC: begin
        if (bus.flush)             w_next = S_IDLE;
        else if (r_cnt == 6'd31)   w_next = S_FIX;
      end
      S_FIX:  w_next = bus.flush ? S_IDLE : S_DONE;
      S_DONE: w_next = w_start ? (w_early ? S_FIX : S_CALC) : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 3'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dsr    <= 32'd0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
    end else if (w_start) begin
      r_sel  <= bus.divsel;
      r_dsr  <= w_b_mag;
      // A zero divisor keeps the all-ones quotient unsigned-looking (-1 either way).
      r_qneg <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
      r_rneg <= w_a_neg;
      r_cnt  <= 6'd0;
      r_quo  <= w_early ? w_early_quo : w_a_mag;
      r_rem  <= w_early ? w_early_rem : 32'd0;
    end else begin
      case (r_state)
        S_CALC: if (!bus.flush) begin
          r_cnt <= r_cnt + 6'd1;
          if (!w_trial[33]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= {r_rem[30:0], r_quo[31]};
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end
        S_FIX: if (!bus.flush) r_result <= w_fix_val;
        default: ;
      endcase
    end
  end

  assign bus.div_busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.div_ready  = (r_state == S_DONE);
  assign bus.div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;
  logic clk;
  logic rst_n;
  div_unit_if bus ();

  div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_signed(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b011);
  endfunction

  // Reference: RISC-V M semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic want_q;
    want_q = (sel == 3'b001) || (sel == 3'b010);
    if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
    if (is_signed(sel)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_q ? 32'h8000_0000 : 32'd0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return want_q ? q[31:0] : r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] sel, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_UNIT_EARLY_OUT_EN
    longint aa, ab;
    if (is_signed(sel)) begin
      aa = longint'($signed(a)); ab = longint'($signed(b));
      if (aa < 0) aa = -aa;
      if (ab < 0) ab = -ab;
    end else begin
      aa = longint'({32'd0, a}); ab = longint'({32'd0, b});
    end
    if (b == 32'd0 || (is_signed(sel) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || aa < ab)
      return 2;
    return 34;
`else
    return 34 + 0 * (sel + a + b);
`endif
  endfunction

  // Counts negedges after the accepting edge until div_ready is seen.
  task automatic wait_ready(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.div_ready) begin
        lat = k;
        break;
      end
      if (bus.div_busy) busy_cnt++;
    end
  endtask

  // Caller sits just after a negedge; accepting edge is the next posedge.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b);
    int lat, bc, exp_lat;
    logic [31:0] exp_res;
    exp_res = ref_result(sel, a, b);
    exp_lat = ref_lat(sel, a, b);
    bus.div_inst = 1'b1; bus.divsel = sel; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 bus.div_inst = 1'b0;
    wait_ready(lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
    check({tag, "_res"}, bus.div_result, exp_res);
    last_res = exp_res;
    @(negedge clk);
    check({tag, "_pulse1"}, {31'd0, bus.div_ready}, 32'd0);
  endtask

  initial begin
    int lat, bc, quiet;
    logic [2:0] sel;
    logic [31:0] a, b;
    bus.div_inst = 1'b0; bus.divsel = 3'b010; bus.flush = 1'b0;
    bus.dividend = 32'd0; bus.divisor = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", {31'd0, bus.div_busy}, 32'd0);
    check("rst_ready", {31'd0, bus.div_ready}, 32'd0);
    check("rst_result", bus.div_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // first edge after reset release must accept
    run_op("divu_100_7", 3'b010, 32'd100, 32'd7);
    run_op("rem_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2);
    run_op("div_m7_2", 3'b001, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("remu_5_0", 3'b100, 32'd5, 32'd0);
    run_op("divu_5_0", 3'b010, 32'd5, 32'd0);
    run_op("div_m5_0", 3'b001, 32'hFFFF_FFFB, 32'd0);
    run_op("rem_m5_0", 3'b011, 32'hFFFF_FFFB, 32'd0);
    run_op("div_3_m10", 3'b001, 32'd3, 32'hFFFF_FFF6);

    // flush at cycle 10 of CALC
    bus.div_inst = 1'b1; bus.divsel = 3'b010; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.div_inst = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.div_busy}, 32'd0);
    quiet = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.div_ready || bus.div_busy) quiet++;
    end
    check("flush_no_ready", 32'(quiet), 32'd0);
    check("flush_keep_res", bus.div_result, last_res);
    run_op("divu_9_3", 3'b010, 32'd9, 32'd3);

    // illegal divsel and flush-over-start in IDLE are both ignored
    bus.div_inst = 1'b1; bus.divsel = 3'b101; bus.dividend = 32'd8; bus.divisor = 32'd2;
    @(negedge clk);
    check("illegal_sel", {31'd0, bus.div_busy}, 32'd0);
    bus.divsel = 3'b010; bus.flush = 1'b1;
    @(negedge clk);
    check("flush_prio", {31'd0, bus.div_busy}, 32'd0);
    bus.flush = 1'b0; bus.div_inst = 1'b0;

    // back-to-back: div_inst held, second start accepted in DONE
    bus.div_inst = 1'b1; bus.divsel = 3'b010; bus.dividend = 32'd20; bus.divisor = 32'd4;
    @(posedge clk);
    wait_ready(lat, bc);
    check("b2b1_lat", 32'(lat), 32'd34);
    check("b2b1_res", bus.div_result, 32'd5);
    bus.dividend = 32'd21;
    @(posedge clk);
    #1 bus.div_inst = 1'b0;
    wait_ready(lat, bc);
    check("b2b2_lat", 32'(lat), 32'd34);
    check("b2b2_busy", 32'(bc), 32'd33);
    check("b2b2_res", bus.div_result, 32'd5);
    last_res = 32'd5;
    @(negedge clk);

    // randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      sel = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin b = $urandom; a = 32'($urandom_range(0, 100)); end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), sel, a, b);
    end

    // reset asserted mid-CALC
    bus.div_inst = 1'b1; bus.divsel = 3'b010; bus.dividend = 32'd777; bus.divisor = 32'd5;
    @(posedge clk);
    #1 bus.div_inst = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.div_busy}, 32'd0);
    check("midrst_ready", {31'd0, bus.div_ready}, 32'd0);
    check("midrst_result", bus.div_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.div_ready || bus.div_busy) quiet++;
    end
    check("midrst_quiet", 32'(quiet), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
